// File: rtl/alu_pkg.sv
// alu_pkg: opcode enums, FSM states and instruction-class constants for alu_mdu_controller.
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD     = 4'd0,
    ALU_SUB     = 4'd1,
    ALU_AND     = 4'd2,
    ALU_OR      = 4'd3,
    ALU_XOR     = 4'd4,
    ALU_U_LOWER = 4'd9,
    ALU_S_LOWER = 4'd10,
    ALU_SLL     = 4'd13,
    ALU_SRL     = 4'd14,
    ALU_SRA     = 4'd15
  } alu_op_e;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  localparam logic [3:0] OPT_OP    = 4'b0110;
  localparam logic [3:0] OPT_OPIMM = 4'b0010;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: radix-2 shift-add multiply / restoring divide on magnitudes, one bit per cycle.
// Runs XLEN cycles after i_start, o_done marks the last iteration; no backpressure, i_abort stops it.
module mdu_iter_core #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_a_mag,
  input  logic [XLEN-1:0] i_b_mag,
  output logic            o_done,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);
  logic [XLEN-1:0]  r_hi, r_lo, r_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic [XLEN:0]    w_sum, w_shift, w_diff;
  logic [XLEN-1:0]  w_hi_nxt, w_lo_nxt;

  // r_lo starts as multiplier/dividend and is shifted out as product-low/quotient bits arrive
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_b};
    if (r_is_div) begin
      if (w_diff[XLEN]) begin
        w_hi_nxt = w_shift[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
      end else begin
        w_hi_nxt = w_diff[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
      end
    end else begin
      w_hi_nxt = w_sum[XLEN:1];
      w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
    end else if (i_abort) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_hi     <= '0;
      r_lo     <= i_a_mag;
      r_b      <= i_b_mag;
      r_cnt    <= CNT_W'(XLEN);
      r_is_div <= i_is_div;
    end else if (r_cnt != '0) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == CNT_W'(1));
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
endmodule

// File: rtl/alu_mdu_controller.sv
// alu_mdu_controller: combinational base-ALU decode plus handshaked RV32M/RV64M unit (MDU_FAST_MUL_EN: 1-cycle MUL).
// Latency XLEN+1 (1 for div-by-zero/overflow/fast MUL); ready_out low while busy, valid_in ignored until IDLE.
module alu_mdu_controller
  import alu_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic            flush,
  input  logic [6:0]      func_7_bits,
  input  logic [2:0]      func_3_bits,
  input  logic [3:0]      alu_option,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic [3:0]      alu_operation,
  output logic            is_mdu,
  output logic [XLEN-1:0] mdu_result,
  output logic            result_valid,
  output logic            busy
);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        r_state, w_state_nxt;
  mdu_op_e           r_op, w_op;
  alu_op_e           w_alu;
  logic              r_neg_q, r_neg_r, r_spec;
  logic [XLEN-1:0]   r_spec_val, r_result;
  logic              w_accept, w_a_sgn, w_b_sgn, w_neg_a, w_neg_b;
  logic              w_div_zero, w_div_ovf, w_fast_mul, w_to_done, w_core_done;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_spec_val, w_hi, w_lo, w_q, w_r, w_fix;
  logic [2*XLEN-1:0] w_prod_it;

  assign w_op = mdu_op_e'(func_3_bits);

  always_comb begin
    is_mdu = (alu_option == OPT_OP) && (func_7_bits == F7_MULDIV);
    w_alu  = ALU_ADD;
    if (!is_mdu && (alu_option == OPT_OP || alu_option == OPT_OPIMM)) begin
      case (func_3_bits)
        3'b000:  w_alu = (alu_option == OPT_OP && func_7_bits[5]) ? ALU_SUB : ALU_ADD;
        3'b001:  w_alu = ALU_SLL;
        3'b010:  w_alu = ALU_S_LOWER;
        3'b011:  w_alu = ALU_U_LOWER;
        3'b100:  w_alu = ALU_XOR;
        3'b101:  w_alu = func_7_bits[5] ? ALU_SRA : ALU_SRL;
        3'b110:  w_alu = ALU_OR;
        default: w_alu = ALU_AND;
      endcase
    end
  end
  assign alu_operation = w_alu;

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
`endif

  // Operand signedness per funct3: MUL family rs1 signed except MULHU, rs2 signed for MUL/MULH; DIV/REM signed
  always_comb begin
    w_a_sgn    = func_3_bits[2] ? !func_3_bits[0] : (func_3_bits[1:0] != 2'b11);
    w_b_sgn    = func_3_bits[2] ? !func_3_bits[0] : !func_3_bits[1];
    w_neg_a    = w_a_sgn & operand_a[XLEN-1];
    w_neg_b    = w_b_sgn & operand_b[XLEN-1];
    w_a_mag    = w_neg_a ? -operand_a : operand_a;
    w_b_mag    = w_neg_b ? -operand_b : operand_b;
    w_div_zero = func_3_bits[2] && (operand_b == '0);
    w_div_ovf  = func_3_bits[2] && !func_3_bits[0] && (operand_a == MOST_NEG) && (operand_b == '1);
    w_spec_val = func_3_bits[1] ? (w_div_zero ? operand_a : '0) : (w_div_zero ? '1 : MOST_NEG);
    w_fast_mul = 1'b0;
`ifdef MDU_FAST_MUL_EN
    w_fast_prod = {{XLEN{w_neg_a}}, operand_a} * {{XLEN{w_neg_b}}, operand_b};
    if (!func_3_bits[2]) begin
      w_fast_mul = 1'b1;
      w_spec_val = (func_3_bits[1:0] == 2'b00) ? w_fast_prod[XLEN-1:0] : w_fast_prod[2*XLEN-1:XLEN];
    end
`endif
    w_to_done  = w_div_zero | w_div_ovf | w_fast_mul;
  end

  assign w_accept = (r_state == IDLE) && valid_in && is_mdu && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    ready_out    = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      IDLE: begin
        ready_out = 1'b1;
        if (w_accept) w_state_nxt = w_to_done ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (w_core_done) w_state_nxt = DONE;
      end
      DONE: begin
        busy         = 1'b1;
        result_valid = !flush;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  mdu_iter_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept && !w_to_done),
    .i_abort  (flush),
    .i_is_div (func_3_bits[2]),
    .i_a_mag  (w_a_mag),
    .i_b_mag  (w_b_mag),
    .o_done   (w_core_done),
    .o_hi     (w_hi),
    .o_lo     (w_lo)
  );

  always_comb begin
    w_prod_it = {w_hi, w_lo};
    if (r_neg_q) w_prod_it = -w_prod_it;
    w_q = r_neg_q ? -w_lo : w_lo;
    w_r = r_neg_r ? -w_hi : w_hi;
    case (r_op)
      MDU_MUL:                         w_fix = w_prod_it[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: w_fix = w_prod_it[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               w_fix = w_q;
      default:                         w_fix = w_r;
    endcase
    if (r_spec) w_fix = r_spec_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= MDU_MUL;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_val <= '0;
      r_result   <= '0;
    end else begin
      if (w_accept) begin
        r_op       <= w_op;
        r_neg_q    <= w_neg_a ^ w_neg_b;
        r_neg_r    <= w_neg_a;
        r_spec     <= w_to_done;
        r_spec_val <= w_spec_val;
      end
      if (result_valid) r_result <= w_fix;
    end
  end

  // The fixed-up value is shown live in DONE and held afterwards
  assign mdu_result = result_valid ? w_fix : r_result;
endmodule

// File: tb/tb_alu_mdu_controller.sv
// Bench for alu_mdu_controller (XLEN=32): directed decode/handshake steps plus random M ops vs an arithmetic model.
module tb_alu_mdu_controller;
  logic        clk = 1'b0;
  logic        rst, valid_in, flush;
  logic [6:0]  func_7_bits;
  logic [2:0]  func_3_bits;
  logic [3:0]  alu_option;
  logic [31:0] operand_a, operand_b;
  logic        ready_out, is_mdu, result_valid, busy;
  logic [3:0]  alu_operation;
  logic [31:0] mdu_result;

  int n_cmp = 0;
  int n_bad = 0;

  alu_mdu_controller #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out), .flush(flush),
    .func_7_bits(func_7_bits), .func_3_bits(func_3_bits), .alu_option(alu_option),
    .operand_a(operand_a), .operand_b(operand_b), .alu_operation(alu_operation),
    .is_mdu(is_mdu), .mdu_result(mdu_result), .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural RV32M definitions
  function automatic void ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int lat);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    lat = 33;
    p   = '0;
    case (f3)
      3'd0, 3'd1: p = sa * sb;
      3'd2:       p = sa * ub;
      3'd3:       p = ua * ub;
      3'd4: if (b == 0) begin p = '1; lat = 1; end
            else if (ovf) begin p = 64'h8000_0000; lat = 1; end
            else p = sa / sb;
      3'd5: if (b == 0) begin p = '1; lat = 1; end else p = ua / ub;
      3'd6: if (b == 0) begin p = ua; lat = 1; end
            else if (ovf) begin p = '0; lat = 1; end
            else p = sa % sb;
      default: if (b == 0) begin p = ua; lat = 1; end else p = ua % ub;
    endcase
    r = (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3) ? p[63:32] : p[31:0];
  endfunction

  task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    valid_in    = 1'b1;
    alu_option  = 4'b0110;
    func_7_bits = 7'b0000001;
    func_3_bits = f3;
    operand_a   = a;
    operand_b   = b;
  endtask

  // Called #1 after a rising edge with the unit idle
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int          exp_lat, lat;
    logic        seen;
    ref_mdu(f3, a, b, exp, exp_lat);
    drive_m(f3, a, b);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      valid_in  = 1'b0;
      operand_a = $urandom;
      operand_b = $urandom;
      if (lat == 1) begin
        check($sformatf("busy_after_accept f3=%0d", f3), busy, 1);
        check($sformatf("ready_after_accept f3=%0d", f3), ready_out, 0);
      end
      if (result_valid) begin
        seen = 1'b1;
        check($sformatf("result f3=%0d a=%h b=%h", f3, a, b), mdu_result, exp);
      end
    end
    check($sformatf("result_seen f3=%0d", f3), seen, 1);
    check($sformatf("latency f3=%0d a=%h b=%h", f3, a, b), lat, exp_lat);
    @(posedge clk); #1;
    check("ready_after_done", ready_out, 1);
    check("result_hold", mdu_result, exp);
  endtask

  logic [3:0] d_opt [8] = '{4'b0110, 4'b0110, 4'b0110, 4'b0010, 4'b0010, 4'b0110, 4'b0110, 4'b0110};
  logic [6:0] d_f7  [8] = '{7'h20, 7'h00, 7'h20, 7'h20, 7'h00, 7'h01, 7'h00, 7'h00};
  logic [2:0] d_f3  [8] = '{3'd5, 3'd5, 3'd0, 3'd0, 3'd1, 3'd5, 3'd7, 3'd3};
  logic [3:0] d_alu [8] = '{4'd15, 4'd14, 4'd1, 4'd0, 4'd13, 4'd0, 4'd2, 4'd9};
  logic       d_mdu [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int          npulse;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    rst = 1'b1; valid_in = 1'b0; flush = 1'b0;
    func_7_bits = '0; func_3_bits = '0; alu_option = '0; operand_a = '0; operand_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready_out, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", mdu_result, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      alu_option = d_opt[i]; func_7_bits = d_f7[i]; func_3_bits = d_f3[i];
      #1;
      check($sformatf("decode_alu[%0d]", i), alu_operation, d_alu[i]);
      check($sformatf("decode_mdu[%0d]", i), is_mdu, d_mdu[i]);
    end
    @(posedge clk); #1;
    check("decode_ready", ready_out, 1);

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3);
    run_op(3'd3, 32'hFFFF_FFFE, 32'd3);
    run_op(3'd4, -32'sd7, 32'd2);
    run_op(3'd6, -32'sd7, 32'd2);
    run_op(3'd5, 32'd5, 32'd0);
    run_op(3'd7, 32'd5, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Flush mid-divide: no result may appear afterwards
    drive_m(3'd4, 32'd100, 32'd7);
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", ready_out, 1);
    check("flush_busy", busy, 0);
    npulse = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (result_valid) npulse++;
    end
    check("flush_no_result", npulse, 0);
    run_op(3'd0, 32'd6, 32'd7);

    // Flush coincident with accept: nothing starts
    drive_m(3'd5, 32'd9, 32'd2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; valid_in = 1'b0;
    check("flush_accept_busy", busy, 0);
    check("flush_accept_ready", ready_out, 1);

    // valid_in held while busy: exactly one result
    drive_m(3'd0, 32'd9, 32'd5);
    npulse = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (result_valid) begin
        npulse++;
        check("hold_valid_result", mdu_result, 45);
        valid_in = 1'b0;
      end
    end
    valid_in = 1'b0;
    check("hold_valid_pulses", npulse, 1);

    // Asynchronous reset in the middle of an operation
    drive_m(3'd0, 32'd3, 32'd4);
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("arst_ready", ready_out, 1);
    check("arst_busy", busy, 0);
    check("arst_valid", result_valid, 0);
    check("arst_result", mdu_result, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 40; k++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = 32'($urandom_range(0, 16)) - 32'd8;
        default: rb = $urandom;
      endcase
      run_op(rf3, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_mdu_controller.md
Name: alu_mdu_controller

Overview:
Successor to the single-cycle ALU decoder.
- Decodes base-ISA ALU operations combinationally, exactly as today.
- Adds RV32M/RV64M multiply/divide as a multi-cycle, handshaked unit with an iterative datapath, parametrised in XLEN.
- Sits in EX beside the ALU. The pipeline stalls on ready_out low and captures mdu_result when result_valid is high.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- valid_in  in  1  instruction/operands valid this cycle
- ready_out  out  1  unit can accept an M instruction
- flush  in  1  abort in-flight M operation
- func_7_bits  in  7  instruction funct7
- func_3_bits  in  3  instruction funct3
- alu_option  in  4  instruction class from main control
- operand_a  in  XLEN  rs1 value
- operand_b  in  XLEN  rs2 value
- alu_operation  out  4  base ALU op code, combinational
- is_mdu  out  1  decoded instruction is an M-extension op, combinational
- mdu_result  out  XLEN  M-extension result
- result_valid  out  1  mdu_result valid, one-cycle pulse
- busy  out  1  M operation in flight

Behaviour:
- Clock/reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state=IDLE, ready_out=1, busy=0, result_valid=0, mdu_result=0, counter=0.
- Base decode (combinational, no state):
  - alu_operation follows the existing 4-bit encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, U_LOWER=9, S_LOWER=10, SHIFT_LEFT=13, SHIFT_RIGHT_LOGIC=14, SHIFT_RIGHT_ARIT=15.
  - Extended over today's decode: R/I-type funct3=001 -> SHIFT_LEFT; funct3=101 -> SRL or SRA selected by func_7_bits[5].
- M-extension detect: is_mdu = (alu_option==4'b0110) && (func_7_bits==7'b0000001). When is_mdu=1, alu_operation=ADD (don't care).
- Accept: in IDLE, valid_in && is_mdu && ready_out. Operands and funct3 are latched on that edge.
- FSM: IDLE -> CALC -> DONE -> IDLE.
  - CALC runs exactly XLEN cycles.
  - DONE lasts one cycle with result_valid=1.
  - Latency: acceptance edge to result_valid = XLEN+1 cycles.
- ready_out=1 only in IDLE. busy=1 in CALC and DONE.
- MUL family (funct3 000-011):
  - Radix-2 shift-add on operand magnitudes, giving a 2*XLEN product.
  - Product is negated at DONE if the result sign is negative.
  - MUL returns the low XLEN bits. MULH (s*s), MULHSU (s*u), MULHU (u*u) return the high XLEN bits.
- DIV family (funct3 100-111):
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Special cases: detected at accept, skip CALC and go to DONE next cycle (latency 1).
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> operand_a.
  - Signed overflow (a = most-negative, b = -1): DIV -> most-negative; REM -> 0.
- flush:
  - Any state -> IDLE next edge; result_valid suppressed.
  - A flush in the same cycle as accept wins: the operation is not started.
- valid_in while busy: ignored. The pipeline must hold the instruction until ready_out.
- mdu_result holds its last value until the next DONE.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- When defined: MUL family uses one combinational 2*XLEN multiplier. Accept -> DONE directly, latency 1. DIV is unchanged.
- When undefined: iterative multiply as above, latency XLEN+1.
- Decode and handshake are identical in both builds.

Decomposition:
- Package alu_pkg holds:
  - alu_op_e: 4-bit op enum.
  - mdu_op_e: funct3 encodings MUL..REMU.
  - mdu_state_e: IDLE/CALC/DONE.
  - Opcode constants OPT_OP=4'b0110 and OPT_OPIMM=4'b0010, and F7_MULDIV.
- One sub-module, mdu_iter_core: owns the accumulator/shift registers and counter, exposes start/done. The top keeps decode, FSM, sign fix-up and special cases.

Test Plan (XLEN=32):
- Base decode: alu_option=0110, f7=0100000, f3=101 -> alu_operation=15, is_mdu=0, ready_out stays 1.
- MUL: a=0xFFFFFFFE (-2), b=3, f3=000 -> result_valid at cycle 33, mdu_result=0xFFFFFFFA. MULHU with the same operands -> 0x00000002.
- DIV: a=-7, b=2 -> 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). Latency 33 in both cases.
- Divide by zero: DIVU a=5, b=0 -> 0xFFFFFFFF at cycle 1. REMU -> 5. DIV with a=0x80000000, b=-1 -> 0x80000000.
- Flush: accept DIV, assert flush at cycle 10 -> IDLE next edge, no result_valid. A new MUL 6*7 then returns 42.
- Reset/backpressure: valid_in held high while busy -> only one result is produced. Async rst at cycle 5 -> outputs return to reset values without a clock edge.
